// File: rtl/fir_output_stage.sv
// FIR output stage: round/saturate the accumulator to 16 bits, then buffer
// the samples in a small FIFO ahead of the DAC interface.
module fir_output_stage #(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [19:0]              sum_in,
    input  logic                     sum_valid,
    output logic [15:0]              out_sample,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     clip,
    output logic [DROP_W-1:0]        drop_count,
    input  logic                     clr_flags,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic signed [20:0] rnd_sum;
    logic signed [16:0] shifted;
    logic [15:0]        sat_val;
    logic               sat_hit;

    logic [15:0]        s1_data_q;
    logic               s1_valid_q;
    logic [15:0]        mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [LW-1:0]      level_q, level_d;
    logic               clip_q, clip_d;
    logic [DROP_W-1:0]  drop_q, drop_d;

    logic               full;
    logic               rd_en;
    logic               wr_en;
    logic               drop_en;

    // +8 then >>>4 rounds half toward +inf; only the top end can overflow
    assign rnd_sum = {sum_in[19], sum_in} + 21'sd8;
    assign shifted = rnd_sum[20:4];

    always_comb begin
        sat_val = shifted[15:0];
        sat_hit = 1'b0;
        if (shifted > 17'sd32767) begin
            sat_val = 16'h7FFF;
            sat_hit = 1'b1;
        end else if (shifted < -17'sd32768) begin
            sat_val = 16'h8000;
            sat_hit = 1'b1;
        end
    end

    assign out_valid  = (level_q != '0);
    assign out_sample = mem_q[rd_ptr_q];
    assign clip       = clip_q;
    assign drop_count = drop_q;
    assign level      = level_q;

    always_comb begin
        full    = (level_q == LW'(DEPTH));
        rd_en   = out_valid && out_ready;
        wr_en   = s1_valid_q && (!full || rd_en);
        drop_en = s1_valid_q && full && !rd_en;

        level_d = level_q;
        if (wr_en && !rd_en) begin
            level_d = level_q + LW'(1);
        end else if (rd_en && !wr_en) begin
            level_d = level_q - LW'(1);
        end

        clip_d = clip_q | (sum_valid & sat_hit);
        drop_d = drop_q;
        if (drop_en && (drop_q != '1)) begin
            drop_d = drop_q + DROP_W'(1);
        end
        if (clr_flags) begin
            clip_d = 1'b0;
            drop_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            clip_q     <= 1'b0;
            drop_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            s1_valid_q <= sum_valid;
            if (sum_valid) begin
                s1_data_q <= sat_val;
            end
            if (wr_en) begin
                mem_q[wr_ptr_q] <= s1_data_q;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;
            clip_q  <= clip_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_fir_output_stage.sv
// Directed bench for fir_output_stage: rounding table plus FIFO,
// flag and reset corner sequences.
module tb_fir_output_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] sum_in;
    logic        sum_valid;
    logic [15:0] out_sample;
    logic        out_valid;
    logic        out_ready;
    logic        clip;
    logic [7:0]  drop_count;
    logic        clr_flags;
    logic [2:0]  level;

    int checks = 0;
    int errors = 0;

    fir_output_stage #(.DEPTH(4), .DROP_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .sum_in(sum_in),
        .sum_valid(sum_valid),
        .out_sample(out_sample),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .clip(clip),
        .drop_count(drop_count),
        .clr_flags(clr_flags),
        .level(level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [19:0] sum;
        logic [15:0] exp;
        logic        sat;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{20'h00008, 16'h0001, 1'b0};
        vecs[1]  = '{20'h7FFF8, 16'h7FFF, 1'b1};
        vecs[2]  = '{20'h80000, 16'h8000, 1'b0};
        vecs[3]  = '{20'h00000, 16'h0000, 1'b0};
        vecs[4]  = '{20'h00007, 16'h0000, 1'b0};
        vecs[5]  = '{20'hFFFF8, 16'h0000, 1'b0};
        vecs[6]  = '{20'hFFFF7, 16'hFFFF, 1'b0};
        vecs[7]  = '{20'h7FFF7, 16'h7FFF, 1'b0};
        vecs[8]  = '{20'h00018, 16'h0002, 1'b0};
        vecs[9]  = '{20'h12345, 16'h1234, 1'b0};
        vecs[10] = '{20'h80008, 16'h8001, 1'b0};
        vecs[11] = '{20'hEDCBA, 16'hEDCC, 1'b0};

        rst       = 1'b1;
        sum_in    = '0;
        sum_valid = 1'b0;
        out_ready = 1'b1;
        clr_flags = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sample", 32'(out_sample), 32'd0);
        chk("rst_clip", 32'(clip), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        rst = 1'b0;
        tick();

        // Rounding/saturation table, one sample at a time
        for (int i = 0; i < 12; i++) begin
            clr_flags = 1'b1;
            tick();
            clr_flags = 1'b0;
            sum_in    = vecs[i].sum;
            sum_valid = 1'b1;
            tick();
            sum_valid = 1'b0;
            chk("lat1_valid", 32'(out_valid), 32'd0);
            chk("vec_clip", 32'(clip), 32'(vecs[i].sat));
            tick();
            chk("lat2_valid", 32'(out_valid), 32'd1);
            chk("vec_sample", 32'(out_sample), 32'(vecs[i].exp));
            chk("vec_level", 32'(level), 32'd1);
            tick();
            chk("vec_drain", 32'(level), 32'd0);
        end

        // Clip is sticky across a later non-saturating sample
        sum_in    = 20'h7FFF8;
        sum_valid = 1'b1;
        tick();
        sum_valid = 1'b0;
        tick();
        tick();
        chk("clip_set", 32'(clip), 32'd1);
        sum_in    = 20'h80000;
        sum_valid = 1'b1;
        tick();
        sum_valid = 1'b0;
        tick();
        chk("neg_sample", 32'(out_sample), 32'h8000);
        chk("clip_held", 32'(clip), 32'd1);
        tick();

        // Overflow with reader stalled: samples 5 and 6 are dropped
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            sum_in    = 20'(k * 16);
            sum_valid = 1'b1;
            tick();
        end
        sum_valid = 1'b0;
        tick();
        tick();
        chk("full_level", 32'(level), 32'd4);
        chk("full_drop", 32'(drop_count), 32'd2);
        chk("stall_head", 32'(out_sample), 32'd1);
        tick();
        chk("stall_hold", 32'(out_sample), 32'd1);
        chk("stall_valid", 32'(out_valid), 32'd1);

        // Full FIFO with simultaneous read and write keeps level at 4
        sum_in    = 20'(7 * 16);
        sum_valid = 1'b1;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("rd_order", 32'(out_sample), 32'(1 + i));
            sum_in = 20'((8 + i) * 16);
            tick();
            chk("rw_level", 32'(level), 32'd4);
            chk("rw_drop", 32'(drop_count), 32'd2);
        end
        sum_valid = 1'b0;
        for (int j = 0; j < 5; j++) begin
            chk("drain_order", 32'(out_sample), 32'(7 + j));
            tick();
        end
        chk("drain_empty", 32'(level), 32'd0);
        chk("drain_valid", 32'(out_valid), 32'd0);

        // clr_flags beats a same-cycle clip set
        sum_in    = 20'h7FFF8;
        sum_valid = 1'b1;
        clr_flags = 1'b1;
        tick();
        sum_valid = 1'b0;
        clr_flags = 1'b0;
        chk("clr_clip", 32'(clip), 32'd0);
        chk("clr_drop", 32'(drop_count), 32'd0);
        tick();
        chk("clr_sample", 32'(out_sample), 32'h7FFF);
        chk("clr_clip2", 32'(clip), 32'd0);
        tick();

        // Reset with level=3 and a sample in stage 1
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            sum_in    = 20'(k * 16);
            sum_valid = 1'b1;
            tick();
        end
        sum_valid = 1'b0;
        chk("pre_rst_level", 32'(level), 32'd3);
        rst = 1'b1;
        tick();
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_drop", 32'(drop_count), 32'd0);
        rst       = 1'b0;
        sum_in    = 20'(5 * 16);
        sum_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        sum_valid = 1'b0;
        tick();
        chk("post_rst_level", 32'(level), 32'd1);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_sample", 32'(out_sample), 32'd5);
        chk("post_rst_drop", 32'(drop_count), 32'd0);
        tick();
        chk("post_rst_empty", 32'(level), 32'd0);

        // Drop counter saturates at all-ones
        out_ready = 1'b0;
        sum_in    = 20'd16;
        sum_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
        end
        sum_valid = 1'b0;
        tick();
        chk("drop_sat", 32'(drop_count), 32'hFF);
        chk("drop_sat_level", 32'(level), 32'd4);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("drop_clr", 32'(drop_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_output_stage.md
FIR_OUTPUT_STAGE -- requirements
Module: fir_output_stage

Interface
REQ-001 Parameter: DEPTH, 4, number of output FIFO entries (power of two, 2..16).
REQ-002 Parameter: DROP_W, 8, width of the dropped-sample counter.
REQ-003 Port: clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: sum_in  input  20  final tap-chain accumulator output, signed two's complement.
REQ-006 Port: sum_valid  input  1  sum_in holds a new sample this cycle.
REQ-007 Port: out_sample  output  16  signed audio sample to the DAC interface.
REQ-008 Port: out_valid  output  1  out_sample is valid.
REQ-009 Port: out_ready  input  1  consumer accepts out_sample this cycle.
REQ-010 Port: clip  output  1  sticky flag: saturation has occurred.
REQ-011 Port: drop_count  output  DROP_W  samples lost to a full FIFO; saturates at all-ones.
REQ-012 Port: clr_flags  input  1  clears clip and drop_count.
REQ-013 Port: level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-014 Stage 1 SHALL register the round/saturate result and a valid bit on every sum_valid cycle.
REQ-015 Rounding SHALL be a 21-bit signed add of sum_in and 8, followed by an arithmetic shift right by 4 (round half toward +inf).
REQ-016 Saturation SHALL clamp the shifted value to [-32768, 32767] and set clip in the same cycle that the stage-1 register loads.
REQ-017 In stage 2, a valid stage-1 result SHALL be written to the FIFO tail on the next edge, unless the FIFO is full and not being read that cycle.
REQ-018 A stage-2 write refused for lack of space SHALL discard the sample and increment drop_count; drop_count SHALL hold at all-ones once reached.
REQ-019 A read SHALL occur when out_valid and out_ready are both 1; the head pointer SHALL advance on that edge.
REQ-020 A write and a read in the same cycle while the FIFO is full SHALL both succeed, leaving level unchanged.
REQ-021 A write and a read in the same cycle while the FIFO is empty SHALL write only; out_valid SHALL be 0 in that cycle.
REQ-022 out_sample SHALL equal the FIFO head entry; out_valid SHALL equal (level != 0); neither SHALL depend combinationally on out_ready.
REQ-023 Latency from a sum_valid edge to out_valid=1 with the FIFO empty SHALL be exactly 2 clk cycles.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; level SHALL range from 0 to DEPTH.
REQ-025 out_sample and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 clr_flags SHALL have priority over a same-cycle clip set or drop increment; after clr_flags, clip=0 and drop_count=0.
REQ-027 sum_valid asserted on consecutive cycles SHALL produce one FIFO write per cycle with no bubbles.

Reset
REQ-028 While rst=1, the block SHALL set out_valid=0, out_sample=0, clip=0, drop_count=0 and level=0, clear both pointers and clear the stage-1 valid bit.
REQ-029 rst SHALL override every other input; any sample in flight at reset SHALL be lost and SHALL NOT be counted as dropped.
REQ-030 On the first edge after rst falls, the block SHALL accept a sum_valid sample normally.

Verification
REQ-031 sum_in=20'h00008, one sum_valid pulse, out_ready=1 -> out_valid high 2 cycles later with out_sample=16'h0001; clip stays 0.
REQ-032 sum_in=20'h7FFF8 -> out_sample=16'h7FFF and clip=1; sum_in=20'h80000 -> out_sample=16'h8000 and clip unchanged from before.
REQ-033 out_ready=0 with 6 consecutive sum_valid samples 1..6 (scaled by 16), DEPTH=4 -> level=4, drop_count=2, and reads return 1,2,3,4 in order.
REQ-034 FIFO full, out_ready=1, sum_valid continuous -> level stays 4 and drop_count does not change.
REQ-035 clr_flags pulsed in the same cycle as a saturating sample -> clip=0 and drop_count=0 on the next cycle.
REQ-036 rst asserted for 1 cycle with level=3 and a sample in stage 1 -> the next cycle shows level=0, out_valid=0 and drop_count=0.
